// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the CPU MEM stage.
// Define DMEM_ERR_CHECK_EN to flag misaligned / out-of-range accesses on resp_err.
//
// state | meaning
// IDLE  | ready, no request in flight
// WAIT  | request latched, counting down the remaining latency
// RESP  | resp_valid pulse; a store commits on the edge closing this cycle
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [IW-1:0] req_idx, lat_idx, rd_idx;
  logic          req_err, lat_err, rd_err;
  logic          lat_we, rd_we;
  logic [31:0]   lat_wdata, rd_data;
  logic          accept, rd_new, commit;
  logic [31:0]   mem [DEPTH];

  assign req_idx = IW'(32'(req_addr[31:2]) % 32'(DEPTH));

`ifdef DMEM_ERR_CHECK_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (32'(req_addr[31:2]) >= 32'(DEPTH));
`else
  logic unused_addr_lsb;
  assign req_err         = 1'b0;
  assign unused_addr_lsb = ^req_addr[1:0];
`endif

  assign req_ready  = (state != WAIT);
  assign accept     = req_valid && req_ready;
  assign stall      = req_valid && !req_ready;
  assign resp_valid = (state == RESP);
  assign commit     = (state == RESP) && lat_we && !lat_err;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (req_valid) begin
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
          cnt_nxt   = 4'(LATENCY - 1);
        end else if (state == RESP) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the response data comes from the request being accepted
  // this edge, so read straight from the request and forward a committing store.
  assign rd_new  = (LATENCY == 1) && accept;
  assign rd_idx  = rd_new ? req_idx : lat_idx;
  assign rd_err  = rd_new ? req_err : lat_err;
  assign rd_we   = rd_new ? req_we  : lat_we;
  assign rd_data = (commit && (lat_idx == rd_idx)) ? lat_wdata : mem[rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_err   <= req_err;
        lat_idx   <= req_idx;
        lat_wdata <= req_wdata;
      end
      if (state_nxt == RESP) begin
        resp_rdata <= (rd_we || rd_err) ? 32'd0 : rd_data;
        resp_err   <= rd_err;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (commit) mem[lat_idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=2 and one LATENCY=1 instance.
module tb_dmem_responder;

`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   st1   = 0;
  int   st2   = 0;

  logic        v2 = 0, we2 = 0, rdy2, rv2, err2, stall2;
  logic [31:0] a2 = 0, wd2 = 0, rd2;
  logic        v1 = 0, we1 = 0, rdy1, rv1, err1, stall1;
  logic [31:0] a1 = 0, wd1 = 0, rd1;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
    .req_addr(a2), .req_wdata(wd2), .resp_valid(rv2), .resp_rdata(rd2),
    .resp_err(err2), .stall(stall2));

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(a1), .req_wdata(wd1), .resp_valid(rv1), .resp_rdata(rd1),
    .resp_err(err1), .stall(stall1));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops the scoreboard whenever a response pulse is presented.
  always @(negedge clock) begin
    if (stall2) st2++;
    if (stall1) st1++;
    if (rv2 === 1'b1) begin
      if (q2.size() == 0) chk("l2_unexpected_resp", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk({e2.tag, "_rdata"}, rd2, e2.rdata);
        chk({e2.tag, "_err"}, 32'(err2), 32'(e2.err));
        chk({e2.tag, "_cycle"}, cyc, e2.cyc);
      end
    end
    if (rv1 === 1'b1) begin
      if (q1.size() == 0) chk("l1_unexpected_resp", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk({e1.tag, "_rdata"}, rd1, e1.rdata);
        chk({e1.tag, "_err"}, 32'(err1), 32'(e1.err));
        chk({e1.tag, "_cycle"}, cyc, e1.cyc);
      end
    end
  end

  task automatic drive(input bit d, input bit v, input bit we, input logic [31:0] a,
                       input logic [31:0] wd);
    if (d) begin v1 = v; we1 = we; a1 = a; wd1 = wd; end
    else   begin v2 = v; we2 = we; a2 = a; wd2 = wd; end
  endtask

  task automatic wait_ready(input bit d);
    int n = 0;
    while (!(d ? rdy1 : rdy2) && n < 20) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
  endtask

  // Called #1 after a clock edge; returns #1 after the accept edge with valid still high.
  task automatic issue(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input bit err, input string tag, input bit push);
    exp_t e;
    wait_ready(d);
    drive(d, 1'b1, we, a, wd);
    e.rdata = rd; e.err = err; e.tag = tag;
    e.cyc = cyc + (d ? 1 : 2);
    if (push) begin
      if (d) q1.push_back(e);
      else   q2.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  task automatic release_req(input bit d);
    wait_ready(d);
    if (d) v1 = 1'b0; else v2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() + q2.size()) != 0 && n < 50) begin
      @(posedge clock); n++;
    end
    #1;
    chk("drain_queue_empty", 32'(q1.size() + q2.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    v2 = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(rv2), 0);
    chk("rst_resp_rdata", rd2, 0);
    chk("rst_resp_err", 32'(err2), 0);
    chk("rst_stall", 32'(stall2), 0);
    v2 = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Preload and the basic latency / stall check on the LATENCY=2 instance.
    issue(0, 1, 32'h0, 32'd42, 0, 0, "st42_a0", 1);
    issue(0, 1, 32'h8, 32'd77, 0, 0, "st77_a8", 1);
    release_req(0);
    drain();
    st2 = 0;
    issue(0, 0, 32'h0, 0, 32'd42, 0, "ld_a0", 1);
    release_req(0);
    drain();
    chk("stall_cycles_l2", st2, 1);

    // Store then back-to-back load of the same word.
    issue(0, 1, 32'h4, 32'd47, 0, 0, "st47_a4", 1);
    issue(0, 0, 32'h4, 0, 32'd47, 0, "ld_a4_b2b", 1);
    release_req(0);
    drain();

    // Misaligned store and out-of-range load.
    issue(0, 1, 32'h6, 32'd99, 0, ERR_EN, "st99_a6", 1);
    issue(0, 0, 32'h400, 0, ERR_EN ? 32'd0 : 32'd42, ERR_EN, "ld_a400", 1);
    issue(0, 0, 32'h4, 0, ERR_EN ? 32'd47 : 32'd99, 0, "ld_a4_after", 1);
    release_req(0);
    drain();

    // Reset pulse while a store is waiting: dropped, no response, no write.
    issue(0, 1, 32'h8, 32'd5, 0, 0, "st5_dropped", 0);
    v2 = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(rv2), 0);
    chk("midrst_resp_rdata", rd2, 0);
    chk("midrst_resp_err", 32'(err2), 0);
    #2 reset = 1'b0;
    #1;
    chk("postrst_ready", 32'(rdy2), 1);
    repeat (4) @(posedge clock);
    #1;
    issue(0, 0, 32'h0, 0, 32'd42, 0, "ld_a0_postrst", 1);
    issue(0, 0, 32'h8, 0, 32'd77, 0, "ld_a8_kept", 1);
    release_req(0);
    drain();

    // LATENCY=1: full throughput with no stall, plus store-to-load forwarding.
    st1 = 0;
    issue(1, 1, 32'h0, 32'd1, 0, 0, "l1_st_a0", 1);
    issue(1, 1, 32'h4, 32'd2, 0, 0, "l1_st_a4", 1);
    issue(1, 1, 32'h8, 32'd3, 0, 0, "l1_st_a8", 1);
    issue(1, 1, 32'hC, 32'd4, 0, 0, "l1_st_aC", 1);
    issue(1, 0, 32'h0, 0, 32'd1, 0, "l1_ld_a0", 1);
    issue(1, 0, 32'h4, 0, 32'd2, 0, "l1_ld_a4", 1);
    issue(1, 0, 32'h8, 0, 32'd3, 0, "l1_ld_a8", 1);
    issue(1, 0, 32'hC, 0, 32'd4, 0, "l1_ld_aC", 1);
    issue(1, 1, 32'h10, 32'd9, 0, 0, "l1_st_a10", 1);
    issue(1, 0, 32'h10, 0, 32'd9, 0, "l1_ld_a10_fwd", 1);
    release_req(1);
    drain();
    chk("stall_cycles_l1", st1, 0);

    repeat (3) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving load/store requests issued by the pipelined RISCVCPU's MEM stage. Each request completes after a configurable number of cycles. While a request is pending, the block raises a stall indication so the CPU can freeze its pipeline. It replaces the zero-latency DMemory array and is the target-side end of the CPU's data-memory request interface.

Parameters:
DEPTH, 256, number of 32-bit words held.
LATENCY, 2, cycles from the request-accept edge to resp_valid; legal range 1..15.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  CPU presents a request this cycle.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = store (SW), 0 = load (LW).
req_addr  input  32  byte address; word index = req_addr[31:2].
req_wdata  input  32  store data.
resp_valid  output  1  one-cycle pulse: response complete.
resp_rdata  output  32  load data; 0 for stores and for errors.
resp_err  output  1  request was misaligned or out of range; qualified by resp_valid.
stall  output  1  equals req_valid AND NOT req_ready; drives the CPU pipeline freeze.

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - FSM enters IDLE; req_ready=1 once reset deasserts.
  - resp_valid=0, resp_rdata=0, resp_err=0, stall=0 while reset is asserted.
  - Memory contents are not cleared.
- FSM states:
  - IDLE: req_ready=1. On req_valid: latch we/addr/wdata, load cnt=LATENCY-1, go to WAIT (or directly to RESP if LATENCY=1).
  - WAIT: req_ready=0. Decrement cnt each cycle; when cnt reaches 0, go to RESP.
  - RESP: resp_valid=1 for exactly this cycle. req_ready=1, so a new request may be accepted in the same cycle (back-to-back); next state is WAIT/RESP for the new request, otherwise IDLE.
- Latency: resp_valid is asserted exactly LATENCY cycles after the accept edge. Sustained throughput is one request per LATENCY cycles.
- Store commit:
  - The write happens on the edge that ends the RESP cycle.
  - A load issued back-to-back to the same address returns the new data.
  - resp_rdata=0 for stores.
- Load data:
  - resp_rdata is registered from mem[index] and valid during the RESP cycle.
  - It holds that value until the next response; it is cleared only by reset.
- Address checks:
  - Error if req_addr[1:0] != 0 or word index >= DEPTH.
  - On error: resp_err=1, resp_rdata=0, no memory write. Timing is unchanged (still LATENCY cycles).
- There is no response backpressure; the CPU must consume resp_valid when it occurs.
- req_we, req_addr and req_wdata are sampled only at the accept edge; later changes are ignored.
- Reset asserted while in WAIT/RESP: the pending transaction is dropped, no write is committed, and no resp_valid is produced.
- req_valid is ignored in WAIT (stall=1). The CPU holds its request stable until req_ready.

Optional Feature:
DMEM_ERR_CHECK_EN:
- Defined: address checks as above; resp_err is driven.
- Undefined: resp_err is tied to 0; req_addr[1:0] is ignored; the index wraps modulo DEPTH (index = req_addr[31:2] mod DEPTH). Timing is identical.

Test Plan:
- Preload mem[0]=42, LATENCY=2; load addr 0x0 accepted at edge N -> resp_valid high only in cycle N+2, resp_rdata=42, resp_err=0; stall=1 for exactly 1 cycle while the CPU holds req_valid.
- Store 47 to addr 0x4, then a back-to-back load of 0x4 in the RESP cycle -> mem[1]=47, load response rdata=47 two cycles later.
- LATENCY=1, four consecutive loads of 0x0,0x4,0x8,0xC (preload 1,2,3,4) -> resp_valid high four consecutive cycles, rdata 1,2,3,4, stall never asserted.
- With DMEM_ERR_CHECK_EN: store 99 to 0x6 and load from 0x400 (DEPTH=256) -> both give resp_err=1 and rdata=0; mem[1] unchanged at 47. Without the macro: the store to 0x6 writes mem[1]=99.
- Store 5 to 0x8 accepted, then reset pulsed for 3 ns during WAIT -> no resp_valid, mem[2] retains its old value, req_ready=1 after release.
- Reset asserted -> resp_valid=0, resp_rdata=0, resp_err=0 immediately without a clock edge; after release, the first load of 0x0 returns 42.
